// File: rtl/alu_1bit_pkg.sv
// Shared definitions for the single-bit ALU slice: opcode encoding,
// the evaluated-result bundle and a full-adder helper.
package alu_1bit_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_DIV  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_XNOR = 3'b111
   } opcode_t;

   // One evaluated operation: data bit, carry-out and divide-by-zero term.
   typedef struct packed {
      logic result;
      logic cout;
      logic dbz;
   } alu_res_t;

   // Full adder shared by ADD and SUB (SUB feeds the inverted b operand).
   function automatic alu_res_t full_add(input logic x, input logic y, input logic c);
      alu_res_t r;
      r.result = x ^ y ^ c;
      r.cout   = (x & y) | (x & c) | (y & c);
      r.dbz    = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/alu_1bit_comb.sv
// Purely combinational opcode decode and evaluation for one ALU bit.
// Produces result, cout and the divide-by-zero term; no state.
module alu_1bit_comb
   import alu_1bit_pkg::*;
(
   input  logic            a,
   input  logic            b,
   input  logic            cin,
   input  logic [OP_W-1:0] sel,
   output logic            result,
   output logic            cout,
   output logic            dbz
);

   alu_res_t res_s;
   opcode_t  op_s;

   assign op_s = opcode_t'(sel);

   // Evaluate the selected operation; unknown opcodes fall to an all-zero result.
   always_comb begin
      res_s = '0;
      case (op_s)
         OP_ADD:  res_s = full_add(a, b, cin);
         // cin=1 means no incoming borrow; cout=1 means no outgoing borrow.
         OP_SUB:  res_s = full_add(a, ~b, cin);
         OP_MUL: begin
            res_s.result = a & b;
            res_s.cout   = 1'b0;
            res_s.dbz    = 1'b0;
         end
         OP_DIV: begin
            if (b) begin
               res_s.result = a;
               res_s.dbz    = 1'b0;
            end else begin
               res_s.result = 1'b0;
               res_s.dbz    = 1'b1;
            end
            res_s.cout = 1'b0;
         end
         OP_AND:  res_s.result = a & b;
         OP_OR:   res_s.result = a | b;
         OP_XOR:  res_s.result = a ^ b;
         OP_XNOR: res_s.result = ~(a ^ b);
         default: res_s = '0;
      endcase
   end

   assign result = res_s.result;
   assign cout   = res_s.cout;
   assign dbz    = res_s.dbz;

endmodule

// File: rtl/alu_one_bit_chk.sv
// Property checker for the single-bit ALU: opcode-level invariants on the
// combinational core and the timing/hold behaviour of the output stage.
module alu_one_bit_chk #(
   parameter int REG_OUT = 1
) (
   input logic       clk,
   input logic       rst_n,
   input logic       in_valid,
   input logic       b,
   input logic [2:0] sel,
   input logic       comb_result,
   input logic       comb_cout,
   input logic       comb_dbz,
   input logic       result,
   input logic       cout,
   input logic       out_valid
);

   // Only ADD and SUB may produce a carry.
   a_cout_arith_only: assert property (@(posedge clk) disable iff (!rst_n)
      (sel[2] || sel[1]) |-> !comb_cout);

   // Divide-by-zero is exactly DIV with b=0 and forces a zero result.
   a_dbz_def: assert property (@(posedge clk) disable iff (!rst_n)
      comb_dbz == ((sel == 3'b011) && !b));
   a_dbz_zero: assert property (@(posedge clk) disable iff (!rst_n)
      comb_dbz |-> (!comb_result && !comb_cout));

   generate
      if (REG_OUT != 0) begin : g_reg_chk
         a_valid_lat: assert property (@(posedge clk) disable iff (!rst_n)
            in_valid |=> out_valid);
         a_idle_hold: assert property (@(posedge clk) disable iff (!rst_n)
            !in_valid |=> (!out_valid && $stable(result) && $stable(cout)));
      end else begin : g_byp_chk
         a_byp_follow: assert property (@(posedge clk) disable iff (!rst_n)
            (out_valid == in_valid) && (result == comb_result) && (cout == comb_cout));
      end
   endgenerate

endmodule

// File: rtl/alu_one_bit.sv
// Single-bit ALU slice: eight operations selected by a 3-bit opcode.
// REG_OUT=1 registers result/cout/out_valid (one-cycle latency, hold when
// idle); REG_OUT=0 bypasses the register stage.
// Optional macro ALU1_DBZ_FLAG_EN adds a registered divide-by-zero flag (dbz).
module alu_one_bit
   import alu_1bit_pkg::*;
#(
   parameter int REG_OUT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            a,
   input  logic            b,
   input  logic            cin,
   input  logic [OP_W-1:0] sel,
   output logic            result,
   output logic            cout,
`ifdef ALU1_DBZ_FLAG_EN
   output logic            dbz,
`endif
   output logic            out_valid
);

   logic result_s;
   logic cout_s;
   logic dbz_s;

   alu_1bit_comb u_comb (
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sel    (sel),
      .result (result_s),
      .cout   (cout_s),
      .dbz    (dbz_s)
   );

   generate
      if (REG_OUT != 0) begin : g_reg
         logic result_r;
         logic cout_r;
         logic valid_r;

         // Output stage: load on a valid sample, otherwise hold data and drop valid.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               result_r <= 1'b0;
               cout_r   <= 1'b0;
               valid_r  <= 1'b0;
            end else begin
               valid_r <= in_valid;
               if (in_valid) begin
                  result_r <= result_s;
                  cout_r   <= cout_s;
               end else begin
                  result_r <= result_r;
                  cout_r   <= cout_r;
               end
            end
         end

`ifdef ALU1_DBZ_FLAG_EN
         logic dbz_r;

         // Divide-by-zero flag travels with the result it describes.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dbz_r <= 1'b0;
            end else if (in_valid) begin
               dbz_r <= dbz_s;
            end else begin
               dbz_r <= dbz_r;
            end
         end

         assign dbz = dbz_r;
`endif

         assign result    = result_r;
         assign cout      = cout_r;
         assign out_valid = valid_r;
      end else begin : g_bypass
         // Bypass still forces quiet outputs while reset is held.
         assign result    = rst_n & result_s;
         assign cout      = rst_n & cout_s;
         assign out_valid = rst_n & in_valid;
`ifdef ALU1_DBZ_FLAG_EN
         assign dbz       = rst_n & dbz_s;
`endif
      end
   endgenerate

   alu_one_bit_chk #(.REG_OUT(REG_OUT)) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .b           (b),
      .sel         (sel),
      .comb_result (result_s),
      .comb_cout   (cout_s),
      .comb_dbz    (dbz_s),
      .result      (result),
      .cout        (cout),
      .out_valid   (out_valid)
   );

endmodule

// File: tb/tb_alu_one_bit.sv
// Self-checking bench for alu_one_bit (REG_OUT=1). Expected values come from
// an arithmetic reference model; each scenario task does its own comparisons.
`timescale 1ns/1ps
module tb_alu_one_bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       a;
   logic       b;
   logic       cin;
   logic [2:0] sel;
   logic       result;
   logic       cout;
   logic       out_valid;
   logic       dbz_obs;

`ifdef ALU1_DBZ_FLAG_EN
   localparam bit DBZ_ON = 1'b1;
   logic dbz;
   assign dbz_obs = dbz;
`else
   localparam bit DBZ_ON = 1'b0;
   assign dbz_obs = 1'b0;
`endif

   int comps = 0;
   int fails = 0;

   // Reference model state: what the outputs should show now.
   logic m_valid, m_res, m_cout, m_dbz;
   logic [3:0] exp_v;
   logic [3:0] obs;

   assign obs   = {out_valid, result, cout, dbz_obs};
   assign exp_v = {m_valid, m_res, m_cout, (DBZ_ON ? m_dbz : 1'b0)};

   always #5 clk = ~clk;

   alu_one_bit #(.REG_OUT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sel       (sel),
      .result    (result),
      .cout      (cout),
`ifdef ALU1_DBZ_FLAG_EN
      .dbz       (dbz),
`endif
      .out_valid (out_valid)
   );

   // Arithmetic model: returns {dbz, result, cout}.
   function automatic logic [2:0] ref_op(input logic ia, input logic ib,
                                         input logic icin, input logic [2:0] isel);
      int x, y, c, s;
      x = int'(ia);
      y = int'(ib);
      c = int'(icin);
      case (isel)
         3'd0: begin s = x + y + c;       return {1'b0, (s % 2) == 1, s >= 2}; end
         3'd1: begin s = x + (1 - y) + c; return {1'b0, (s % 2) == 1, s >= 2}; end
         3'd2: return {1'b0, (x * y) == 1, 1'b0};
         3'd3: begin
            if (y == 0) return 3'b100;
            else        return {1'b0, (x / y) == 1, 1'b0};
         end
         3'd4: return {1'b0, (x * y) == 1, 1'b0};
         3'd5: return {1'b0, (x + y) > 0, 1'b0};
         3'd6: return {1'b0, ((x + y) % 2) == 1, 1'b0};
         3'd7: return {1'b0, ((x + y) % 2) == 0, 1'b0};
         default: return 3'b000;
      endcase
   endfunction

   // Apply inputs, advance one clock, update the model, settle 1ns after the edge.
   task automatic step(input logic v, input logic ia, input logic ib,
                       input logic icin, input logic [2:0] isel);
      in_valid = v; a = ia; b = ib; cin = icin; sel = isel;
      @(posedge clk);
      if (!rst_n) begin
         {m_valid, m_res, m_cout, m_dbz} = 4'b0000;
      end else begin
         m_valid = v;
         if (v) {m_dbz, m_res, m_cout} = ref_op(ia, ib, icin, isel);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      {m_valid, m_res, m_cout, m_dbz} = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
         comps++;
         if (obs !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold[%0d]: got %b want 0000 (valid,result,cout,dbz)", i, obs);
         end
      end
      rst_n = 1'b1;
      #1;
      comps++;
      if (obs !== 4'b0000) begin
         fails++;
         $display("FAIL reset_release: got %b want 0000", obs);
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
      comps++;
      if (obs !== exp_v || obs !== 4'b1010) begin
         fails++;
         $display("FAIL first_result: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_add_sub();
      logic [3:0] vec [4] = '{4'b0100, 4'b0110, 4'b1101, 4'b1011}; // {sub,a,b,cin}
      logic [3:0] v;
      for (int i = 0; i < 4; i++) begin
         v = vec[i];
         step(1'b1, v[2], v[1], v[0], {2'b00, v[3]});
         comps++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL add_sub[%0d]: got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_mul_div();
      logic [3:0] vec [4] = '{4'b0011, 4'b0001, 4'b1011, 4'b1010}; // {div,-,a,b}
      logic [3:0] v;
      for (int i = 0; i < 4; i++) begin
         v = vec[i];
         step(1'b1, v[1], v[0], 1'b1, v[3] ? 3'b011 : 3'b010);
         comps++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL mul_div[%0d]: got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] vec [8] = '{5'b10010, 5'b10011, 5'b10101, 5'b10100,
                              5'b11011, 5'b11001, 5'b11111, 5'b11110}; // {sel,a,b}
      logic [4:0] v;
      for (int i = 0; i < 8; i++) begin
         v = vec[i];
         step(1'b1, v[1], v[0], 1'b1, v[4:2]);
         comps++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL logic_b2b[%0d]: got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_hold_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'b101);
      comps++;
      if (obs !== exp_v || obs !== 4'b0010) begin
         fails++;
         $display("FAIL idle_hold: got %b want %b", obs, exp_v);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'b011);
      comps++;
      if (obs !== 4'b0010) begin
         fails++;
         $display("FAIL idle_hold2: got %b want 0010", obs);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
      rst_n = 1'b0;
      {m_valid, m_res, m_cout, m_dbz} = 4'b0000;
      #1;
      comps++;
      if (obs !== 4'b0000) begin
         fails++;
         $display("FAIL async_clear: got %b want 0000", obs);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 3'b001);
      rst_n = 1'b1;
      #1;
      comps++;
      if (obs !== 4'b0000) begin
         fails++;
         $display("FAIL post_release: got %b want 0000", obs);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              1'($urandom), 3'($urandom));
         comps++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL random[%0d]: got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0; sel = 3'b000;
      test_reset();
      test_add_sub();
      test_mul_div();
      test_back_to_back();
      test_hold_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
      $finish;
   end

endmodule
